// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types: queue entry layout, NOP encoding and memory latency.
package fetch_stage_pkg;

  localparam int unsigned PIPE_XLEN    = 32;
  localparam int unsigned ILEN         = 32;
  localparam int unsigned IMEM_LATENCY = 1;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PIPE_XLEN-1:0] pc;
    logic [ILEN-1:0]      instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush and occupancy count.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           mem_we_c;

  // Pointer and occupancy update; flush discards everything, including a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_we_c = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      mem_we_c = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: credit-based request issue, epoch-tagged response
// filtering and a registered prefetch queue feeding decode.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     FQ_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int unsigned CW  = $clog2(FQ_DEPTH) + 1;
  localparam int unsigned CRW = CW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d;
  logic            epoch_q, epoch_d;

  logic [CW-1:0]   fq_count;
  fetch_entry_t    fq_head;
  fetch_entry_t    push_entry_c;
  logic            pop_c, push_c, issue_c, valid_c;
  logic [CRW-1:0]  credit_c;

  fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push_c),
    .push_data (push_entry_c),
    .pop       (pop_c),
    .head      (fq_head),
    .count     (fq_count)
  );

  // Handshake, credit check and next-state; redirect overrides pop, push and issue.
  always_comb begin
    valid_c            = !rst && (fq_count != '0);
    pop_c              = valid_c && id_ready && !redirect_valid;
    credit_c           = CRW'(fq_count) + CRW'(inflight_q) - CRW'(pop_c);
    issue_c            = !rst && !redirect_valid && (credit_c < CRW'(FQ_DEPTH));
    push_c             = inflight_q && (inflight_epoch_q == epoch_q) && !redirect_valid && !rst;
    push_entry_c.pc    = PIPE_XLEN'(inflight_pc_q);
    push_entry_c.instr = imem_rdata;

    fetch_pc_d       = fetch_pc_q;
    epoch_d          = epoch_q;
    inflight_d       = issue_c;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;

    if (issue_c) begin
      fetch_pc_d       = fetch_pc_q + XLEN'(4);
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
    end
    if (redirect_valid) begin
      epoch_d    = ~epoch_q;
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q       <= RESET_PC;
      inflight_pc_q    <= '0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
    end
  end

  assign imem_req  = issue_c;
  assign imem_addr = fetch_pc_q;
  assign if_valid  = valid_c;
  assign if_pc     = valid_c ? XLEN'(fq_head.pc) : '0;
  assign if_instr  = valid_c ? fq_head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_stage.sv
// Cycle-vector table plus program-order scoreboard for the fetch stage.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_pc, if_instr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return a ^ 32'h1357_0003;
    endcase
  endfunction

  // Fixed one-cycle instruction memory.
  always @(posedge clk) imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst, rdy, redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  vec_t         vecs[$];
  fetch_entry_t sb[$];

  function automatic vec_t mk(input logic r, input logic rdy, input logic rd,
                              input logic [31:0] rpc, input logic req,
                              input logic [31:0] addr, input logic v,
                              input logic [31:0] pc);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.redir = rd; t.rpc = rpc;
    t.e_req = req; t.e_addr = addr; t.e_valid = v;
    t.e_pc    = v ? pc : 32'h0;
    t.e_instr = v ? instr_of(pc) : NOP;
    return t;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] start);
    fetch_entry_t e;
    sb.delete();
    for (int i = 0; i < 64; i++) begin
      e.pc    = start + 32'(4 * i);
      e.instr = instr_of(e.pc);
      sb.push_back(e);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; the scoreboard follows the stimulus.
  task automatic drive(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; id_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
    if (r)       sb_restart(32'h0);
    else if (rd) sb_restart(rpc & ~32'h3);
    #1;
  endtask

  task automatic sb_check(input int step);
    fetch_entry_t e;
    if (!rst && if_valid && id_ready && !redirect_valid) begin
      n_acc++;
      if (sb.size() == 0) begin
        chk("sb_underflow", step, 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", step, if_pc, e.pc);
        chk("sb_instr", step, if_instr, e.instr);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    logic rdy_r, rd_r;
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(posedge clk);

    //             rst rdy rd  rpc            req addr           v  pc
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h10,         1, 32'h8));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h14,         1, 32'hC));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h18,         1, 32'h10));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h1C,         1, 32'h14));
    vecs.push_back(mk(0, 1, 1, 32'h102,        0, 32'h0,          1, 32'h18));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h100,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h104,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h108,        1, 32'h100));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h10C,        1, 32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h108));
    vecs.push_back(mk(0, 1, 1, 32'h200,        0, 32'h0,          1, 32'h108));
    vecs.push_back(mk(0, 1, 1, 32'h300,        0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h300,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h304,        0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h308,        1, 32'h300));
    vecs.push_back(mk(0, 1, 1, 32'hFFFF_FFFE,  0, 32'h0,          1, 32'h304));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'hFFFF_FFFC,  0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h4,          1, 32'hFFFF_FFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4));
    vecs.push_back(mk(1, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h0,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h4,          0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'h8,          1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,          1, 32'hC,          1, 32'h4));

    foreach (vecs[i]) begin
      v = vecs[i];
      drive(v.rst, v.rdy, v.redir, v.rpc);
      chk("imem_req", i, 32'(imem_req), 32'(v.e_req));
      if (v.e_req) chk("imem_addr", i, imem_addr, v.e_addr);
      chk("if_valid", i, 32'(if_valid), 32'(v.e_valid));
      chk("if_pc", i, if_pc, v.e_pc);
      chk("if_instr", i, if_instr, v.e_instr);
      sb_check(i);
    end
    chk("table_accepts", 0, 32'(n_acc), 32'd14);

    // Random decode back-pressure with one redirect; scoreboard catches loss or duplication.
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req", 1000, 32'(imem_req), 32'd0);
    chk("rst_valid", 1000, 32'(if_valid), 32'd0);
    n_acc = 0;
    for (int cyc = 0; cyc < 400 && n_acc < 40; cyc++) begin
      rdy_r = ($urandom_range(0, 3) != 0);
      rd_r  = (cyc == 25);
      drive(1'b0, rdy_r, rd_r, 32'h4003);
      sb_check(2000 + cyc);
    end
    chk("random_progress", 3000, 32'(n_acc >= 40), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
